overlap_acc_stream: RTL and testbench
=====================================

# overlap_acc_stream

Streaming, parametrised successor to the fixed 4-bit Karatsuba overlap stage. It accepts a stream of GF(2) partial products, each 2H-1 bits wide, and places segment i at bit offset i·H. Overlapping bits are XOR-combined, and every K segments the block emits one assembled (K+1)·H-1 bit product. It sits between the partial-product multipliers and the result consumer. A double-buffered output lets frame n+1 accumulate while frame n waits for backpressure to clear.

## Interface
Parameters:
- H, default 2: overlap offset in bits (half operand width); H ≥ 1.
- K, default 3: segments per frame; K ≥ 2.
- W (derived, not overridable): 2H-1, segment width.
- OW (derived, not overridable): (K+1)·H-1, product width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abandon the current partial frame.
- s_valid  in  1  segment present.
- s_ready  out  1  block accepts a segment this cycle.
- s_data  in  W  segment bits.
- m_valid  out  1  assembled product available.
- m_ready  in  1  consumer takes the product this cycle.
- m_data  out  OW  assembled product.

## Operation
- Internal state:
  - cnt: 0..K-1, index of the next segment.
  - acc: OW bits, running XOR.
  - out_full (= m_valid).
  - m_data register.
- Accept condition: s_valid && s_ready.
- Placement: place(d, i) = zero-extend d to OW bits, then shift left by i·H.
- Accept with cnt = 0 (K > 1): acc ← place(s_data, 0). This overwrites acc, so no stale XOR survives. Then cnt ← 1.
- Accept with 0 < cnt < K-1: acc ← acc ^ place(s_data, cnt), cnt ← cnt+1.
- Accept with cnt = K-1:
  - m_data ← acc ^ place(s_data, K-1).
  - m_valid ← 1.
  - acc ← 0, cnt ← 0.
- s_ready = !rst && !flush && !(cnt == K-1 && m_valid && !m_ready).
  - Non-final segments are never stalled.
  - The final segment is accepted only if the output is empty or is being drained in the same cycle.
- Output handshake:
  - m_valid && m_ready without a new load clears m_valid.
  - A drain and a load in the same cycle leave m_valid = 1 and m_data = the new product.
  - m_data is held stable while m_valid && !m_ready.
- flush:
  - Sets cnt ← 0 and acc ← 0.
  - Leaves m_valid and m_data untouched.
  - A segment presented during flush is not accepted.
- Arithmetic: pure XOR (carry-less), no carries. Bits of place() at or above OW are impossible by construction.

## Timing
- Reset values: m_valid = 0, m_data = 0, cnt = 0, acc = 0. s_ready = 0 while rst is high and 1 in the first cycle after.
- Latency: final segment accepted at edge t → m_valid = 1 and m_data valid after edge t (visible in cycle t+1).
- Throughput: one segment per cycle, one product every K cycles when m_ready is held high. No bubble between frames.
- Backpressure stalls only at cnt = K-1. Once m_ready rises, that same cycle accepts the final segment and drains the old product.
- Reset mid-frame: partial frame and any pending output are discarded.
- flush and a final segment in the same cycle: flush wins and no product is produced.
- rst has priority over flush, which has priority over accept.

## Structure
- Package kara_pkg holds:
  - functions seg_w(H) and prod_w(H, K);
  - the GF(2) place/XOR helper, shared with the other Karatsuba stages.
- Sub-module kara_overlap_place: combinational. It takes acc, s_data and cnt and returns acc ^ place(s_data, cnt) via a K-way offset mux.
- The top level holds cnt, acc, the output register and the handshake logic.

## Test plan
- H=2, K=3; segments 3'b101, 3'b011, 3'b110 back-to-back, m_ready=1 → m_data = 7'h69, m_valid high for exactly 1 cycle, 1 cycle after the third accept.
- H=2, K=3, m_ready=0; frame A as above, then frame B = 3'b111 ×3:
  - s_ready drops when B's third segment is presented; m_data holds 7'h69.
  - Raise m_ready → B's third segment is accepted that cycle; next cycle m_data = 7'h6B.
- Continuous valid input with m_ready=1 over 4 frames → m_valid pulses every 3 cycles, s_ready never drops, no segment lost.
- flush asserted after 2 segments, then a fresh frame 3'b101, 3'b011, 3'b110 → m_data = 7'h69, with no contribution from the flushed segments. Repeat with flush coincident with the third segment → no product.
- rst asserted mid-frame with a pending m_valid → next cycle m_valid = 0, m_data = 0, cnt = 0; the following full frame assembles correctly.
- H=4, K=2 (W=7, OW=11); segments 7'h7F, 7'h7F → m_data = 11'h78F.

Source files
------------

// File: rtl/kara_pkg.sv
// Shared GF(2) helpers for the Karatsuba stages: width functions and the
// carry-less place/XOR primitive.
package kara_pkg;

  localparam int GF2_MAX_W = 64;

  typedef logic [GF2_MAX_W-1:0] gf2_word_t;

  function automatic int seg_w(input int h);
    return 2 * h - 1;
  endfunction

  function automatic int prod_w(input int h, input int k);
    return (k + 1) * h - 1;
  endfunction

  // acc ^ (d << sh) over GF(2); callers truncate to their own product width
  function automatic gf2_word_t gf2_place_xor(input gf2_word_t acc, input gf2_word_t d,
                                              input int unsigned sh);
    return acc ^ (d << sh);
  endfunction

endpackage

// File: rtl/overlap_acc_stream_if.sv
// Segment-in / product-out stream bundle for overlap_acc_stream.
interface overlap_acc_stream_if
  import kara_pkg::*;
#(
  parameter int H = 2,
  parameter int K = 3
);
  localparam int W  = seg_w(H);
  localparam int OW = prod_w(H, K);

  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/kara_overlap_place.sv
// Combinational overlap step: o_sum = i_acc ^ place(i_data, i_cnt), where the
// offset i_cnt*H is chosen through a K-way mux of pre-shifted copies.
module kara_overlap_place
  import kara_pkg::*;
#(
  parameter int H = 2,
  parameter int K = 3,
  localparam int W  = seg_w(H),
  localparam int OW = prod_w(H, K),
  localparam int CW = $clog2(K)
) (
  input  logic [OW-1:0] i_acc,
  input  logic [W-1:0]  i_data,
  input  logic [CW-1:0] i_cnt,
  output logic [OW-1:0] o_sum
);

  gf2_word_t     w_data_ext;
  logic [OW-1:0] w_placed [K];
  logic [OW-1:0] w_sel;

  assign w_data_ext = gf2_word_t'(i_data);

  for (genvar gi = 0; gi < K; gi++) begin : g_place
    assign w_placed[gi] = OW'(gf2_place_xor('0, w_data_ext, gi * H));
  end

  // one-hot OR of the offset copies, then the carry-less add into acc
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < K; i++) begin
      w_sel = w_sel | ((i_cnt == CW'(i)) ? w_placed[i] : '0);
    end
    o_sum = i_acc ^ w_sel;
  end

endmodule

// File: rtl/overlap_acc_stream.sv
// Streaming GF(2) overlap accumulator: XOR-assembles K segments at offsets i*H
// into one product, with a single output register that drains under backpressure.
module overlap_acc_stream
  import kara_pkg::*;
#(
  parameter int H = 2,
  parameter int K = 3
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush,
  overlap_acc_stream_if.slave  bus
);

  localparam int W  = seg_w(H);
  localparam int OW = prod_w(H, K);
  localparam int CW = $clog2(K);

  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_m_data;
  logic          r_m_valid;

  logic          w_last;
  logic          w_s_ready;
  logic          w_accept;
  logic [OW-1:0] w_acc_in;
  logic [OW-1:0] w_sum;

  assign w_last    = (r_cnt == CW'(K - 1));
  // only the closing segment can stall, and only while the output is stuck
  assign w_s_ready = !rst && !flush && !(w_last && r_m_valid && !bus.m_ready);
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_acc_in  = (r_cnt == '0) ? '0 : r_acc;

  kara_overlap_place #(
    .H (H),
    .K (K)
  ) u_place (
    .i_acc  (w_acc_in),
    .i_data (bus.s_data),
    .i_cnt  (r_cnt),
    .o_sum  (w_sum)
  );

  // frame state: segment index and running XOR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= w_sum;
      end
    end else begin
      r_cnt <= r_cnt;
      r_acc <= r_acc;
    end
  end

  // output register: a load in the same cycle as a drain keeps m_valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_accept && w_last) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sum;
    end else if (r_m_valid && bus.m_ready) begin
      r_m_valid <= 1'b0;
      r_m_data  <= r_m_data;
    end else begin
      r_m_valid <= r_m_valid;
      r_m_data  <= r_m_data;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;

endmodule

// File: tb/tb_overlap_acc_stream.sv
// Bench for overlap_acc_stream: directed vector table, randomized run against a
// segment-list reference model, and a hand sequence for H=4, K=2.
module tb_overlap_acc_stream;
  import kara_pkg::*;

  localparam int H   = 2;
  localparam int K   = 3;
  localparam int OW  = 7;
  localparam int HB  = 4;
  localparam int KB  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, rst_b, flush_b;

  overlap_acc_stream_if #(.H(H),  .K(K))  bus_a();
  overlap_acc_stream_if #(.H(HB), .K(KB)) bus_b();

  overlap_acc_stream #(.H(H), .K(K)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_a)
  );

  overlap_acc_stream #(.H(HB), .K(KB)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .bus(bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  typedef struct {
    logic       r;
    logic       fl;
    logic       sv;
    logic [2:0] sd;
    logic       mr;
    logic       e_rdy;
    logic       e_mv;
    logic [6:0] e_md;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic fl, input logic sv, input logic [2:0] sd,
                     input logic mr, input logic rdy, input logic mv, input logic [6:0] md);
    tbl.push_back('{r, fl, sv, sd, mr, rdy, mv, md});
  endtask

  // reference model: list of accepted segments plus the one-deep output slot
  int         seg_q[$];
  bit         m_full;
  logic [6:0] m_exp;

  function automatic logic [OW-1:0] assemble(input int q[$]);
    logic [63:0] p;
    p = 64'd0;
    foreach (q[i]) p = p ^ (64'(q[i]) << (i * H));
    return OW'(p);
  endfunction

  task automatic run_random(input int n, input bit cont);
    logic r, fl, sv, mr, rdy, loaded;
    logic [2:0] sd;
    for (int c = 0; c < n; c++) begin
      r  = (c == 0) ? 1'b1 : (cont ? 1'b0 : ($urandom_range(63) == 0));
      fl = cont ? 1'b0 : ($urandom_range(15) == 0);
      sv = cont ? 1'b1 : ($urandom_range(3) != 0);
      mr = cont ? 1'b1 : 1'($urandom_range(1));
      sd = 3'($urandom_range(7));
      rst = r; flush = fl; bus_a.s_valid = sv; bus_a.s_data = sd; bus_a.m_ready = mr;
      rdy = !r && !fl && !(seg_q.size() == K - 1 && m_full && !mr);
      #1;
      check($sformatf("rnd%0d s_ready", c), bus_a.s_ready, rdy);
      @(posedge clk);
      if (r) begin
        seg_q.delete();
        m_full = 1'b0;
        m_exp  = 7'h00;
      end else begin
        loaded = 1'b0;
        if (fl) begin
          seg_q.delete();
        end else if (sv && rdy) begin
          seg_q.push_back(int'(sd));
          if (seg_q.size() == K) begin
            m_exp  = assemble(seg_q);
            m_full = 1'b1;
            loaded = 1'b1;
            seg_q.delete();
          end
        end
        if (m_full && mr && !loaded) m_full = 1'b0;
      end
      #1;
      check($sformatf("rnd%0d m_valid", c), bus_a.m_valid, m_full);
      check($sformatf("rnd%0d m_data", c), bus_a.m_data, m_exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_data = 3'b000; bus_a.m_ready = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_data = 7'h00; bus_b.m_ready = 1'b0;

    //   r     fl    sv    sd      mr    rdy   mv    md
    add(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 7'h69);
    // backpressure: frame A, then frame B stalls on its last segment
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 7'h6B);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 7'h6B);
    // flush after two segments, then a clean frame
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 7'h6B);
    add(1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 7'h6B);
    add(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 7'h6B);
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 7'h6B);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 7'h6B);
    add(1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 7'h69);
    // flush coincident with the final segment: no product
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 7'h69);
    add(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 7'h6B);
    // reset mid-frame with a pending product
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 7'h6B);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 7'h6B);
    add(1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 7'h00);
    add(1'b0, 1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 7'h69);
    add(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 7'h69);

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; flush = tbl[i].fl;
      bus_a.s_valid = tbl[i].sv; bus_a.s_data = tbl[i].sd; bus_a.m_ready = tbl[i].mr;
      #1;
      check($sformatf("tbl%0d s_ready", i), bus_a.s_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d m_valid", i), bus_a.m_valid, tbl[i].e_mv);
      check($sformatf("tbl%0d m_data", i), bus_a.m_data, tbl[i].e_md);
    end

    run_random(13, 1'b1);
    run_random(400, 1'b0);

    rst = 1'b0; flush = 1'b0; bus_a.s_valid = 1'b0; bus_a.m_ready = 1'b1;

    // H=4, K=2: 7'h7F twice assembles to 11'h78F
    check("b reset m_valid", bus_b.m_valid, 1'b0);
    check("b reset m_data", bus_b.m_data, 11'h000);
    rst_b = 1'b0; bus_b.s_valid = 1'b1; bus_b.s_data = 7'h7F; bus_b.m_ready = 1'b1;
    #1;
    check("b seg0 s_ready", bus_b.s_ready, 1'b1);
    @(posedge clk);
    #1;
    check("b seg0 m_valid", bus_b.m_valid, 1'b0);
    #1;
    check("b seg1 s_ready", bus_b.s_ready, 1'b1);
    @(posedge clk);
    #1;
    check("b prod m_valid", bus_b.m_valid, 1'b1);
    check("b prod m_data", bus_b.m_data, 11'h78F);
    bus_b.s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b drain m_valid", bus_b.m_valid, 1'b0);
    check("b hold m_data", bus_b.m_data, 11'h78F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
